// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-update signals shared between the pipeline and the predictor.
interface branch_predictor_if;
    logic [31:0] fetch_pc;
    logic [31:0] predict_pc;
    logic        predict_taken;
    logic        predict_ret;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic [1:0]  update_kind;

    // Pipeline side: presents fetch addresses and resolved branches, consumes predictions.
    modport master (
        output fetch_pc, update_valid, update_pc, update_target, update_taken, update_kind,
        input  predict_pc, predict_taken, predict_ret
    );

    // Predictor side.
    modport slave (
        input  fetch_pc, update_valid, update_pc, update_target, update_taken, update_kind,
        output predict_pc, predict_taken, predict_ret
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters plus a circular return-address stack.
// Lookup is purely combinational; every update lands on the next rising clock edge.
module branch_predictor #(
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned RAS_DEPTH   = 8
) (
    input logic               clk,
    input logic               reset,
    branch_predictor_if.slave bp
);
    localparam int unsigned IDX    = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W  = 30 - IDX;
    localparam int unsigned RAS_PW = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W  = RAS_PW + 1;

    localparam logic [1:0] KIND_BR   = 2'b00;
    localparam logic [1:0] KIND_JAL  = 2'b01;
    localparam logic [1:0] KIND_CALL = 2'b10;
    localparam logic [1:0] KIND_RET  = 2'b11;

    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

    // BTB storage; only the valid bits are reset, the rest is qualified by them.
    logic [BTB_ENTRIES-1:0] valid;
    logic [TAG_W-1:0]       tag_mem    [BTB_ENTRIES];
    logic [31:0]            target_mem [BTB_ENTRIES];
    logic [1:0]             ctr_mem    [BTB_ENTRIES];
    logic [1:0]             kind_mem   [BTB_ENTRIES];

    // RAS storage; ras_top addresses the most recent push when ras_count is non-zero.
    logic [31:0]       ras_mem [RAS_DEPTH];
    logic [RAS_PW-1:0] ras_top;
    logic [CNT_W-1:0]  ras_count;

    logic [IDX-1:0]   f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, u_hit;
    logic [31:0]      fall_through;
    logic             ras_empty;
    logic             do_push, do_pop;

    // Byte-offset bits carry no information for aligned instructions.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{bp.fetch_pc[1:0], bp.update_pc[1:0]};

    assign f_idx        = bp.fetch_pc[IDX+1:2];
    assign f_tag        = bp.fetch_pc[31:IDX+2];
    assign u_idx        = bp.update_pc[IDX+1:2];
    assign u_tag        = bp.update_pc[31:IDX+2];
    assign f_hit        = valid[f_idx] && (tag_mem[f_idx] == f_tag);
    assign u_hit        = valid[u_idx] && (tag_mem[u_idx] == u_tag);
    assign fall_through = bp.fetch_pc + 32'd4;
    assign ras_empty    = (ras_count == '0);

    assign do_push = bp.update_valid && bp.update_taken && (bp.update_kind == KIND_CALL);
    assign do_pop  = bp.update_valid && bp.update_taken && (bp.update_kind == KIND_RET) && !ras_empty;

    // Next-PC selection from the current BTB entry and RAS top.
    always_comb begin
        bp.predict_pc    = fall_through;
        bp.predict_taken = 1'b0;
        bp.predict_ret   = 1'b0;
        if (f_hit) begin
            case (kind_mem[f_idx])
                KIND_BR: begin
                    if (ctr_mem[f_idx][1]) begin
                        bp.predict_pc    = target_mem[f_idx];
                        bp.predict_taken = 1'b1;
                    end
                end
                KIND_JAL, KIND_CALL: begin
                    bp.predict_pc    = target_mem[f_idx];
                    bp.predict_taken = 1'b1;
                end
                default: begin
                    if (!ras_empty) begin
                        bp.predict_pc    = ras_mem[ras_top];
                        bp.predict_taken = 1'b1;
                        bp.predict_ret   = 1'b1;
                    end
                end
            endcase
        end
    end

    // Valid bits: cleared asynchronously, set when a taken miss allocates an entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (bp.update_valid && !u_hit && bp.update_taken) begin
            valid[u_idx] <= 1'b1;
        end
    end

    // Entry payload: counter training on hits, rewrite or allocation on taken outcomes.
    always_ff @(posedge clk) begin
        if (bp.update_valid) begin
            if (u_hit) begin
                if (kind_mem[u_idx] == KIND_BR) begin
                    if (bp.update_taken) begin
                        if (ctr_mem[u_idx] != 2'b11) ctr_mem[u_idx] <= ctr_mem[u_idx] + 2'd1;
                    end else begin
                        if (ctr_mem[u_idx] != 2'b00) ctr_mem[u_idx] <= ctr_mem[u_idx] - 2'd1;
                    end
                end
                if (bp.update_taken) begin
                    target_mem[u_idx] <= bp.update_target;
                    kind_mem[u_idx]   <= bp.update_kind;
                end
            end else if (bp.update_taken) begin
                tag_mem[u_idx]    <= u_tag;
                target_mem[u_idx] <= bp.update_target;
                kind_mem[u_idx]   <= bp.update_kind;
                ctr_mem[u_idx]    <= 2'b10;
            end
        end
    end

    // RAS pointer/count: a push when full wraps onto the oldest slot and the count saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ras_top   <= '0;
            ras_count <= '0;
        end else if (do_push) begin
            ras_top <= ras_top + 1'b1;
            if (ras_count != RAS_FULL) ras_count <= ras_count + 1'b1;
        end else if (do_pop) begin
            ras_top   <= ras_top - 1'b1;
            ras_count <= ras_count - 1'b1;
        end
    end

    // RAS data: the return address lands in the slot just above the current top.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_mem[ras_top + 1'b1] <= bp.update_pc + 32'd4;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    branch_predictor_if bp_if ();

    branch_predictor #(
        .BTB_ENTRIES(16),
        .RAS_DEPTH  (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bp   (bp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One resolved instruction, applied across a single rising edge.
    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                       input logic [1:0] kind);
        bp_if.update_pc     = pc;
        bp_if.update_target = tgt;
        bp_if.update_taken  = taken;
        bp_if.update_kind   = kind;
        bp_if.update_valid  = 1'b1;
        @(posedge clk);
        #1;
        bp_if.update_valid  = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic [31:0] exp_pc,
                        input logic exp_t, input logic exp_r);
        bp_if.fetch_pc = pc;
        #1;
        check({tag, "_pc"}, bp_if.predict_pc, exp_pc);
        check({tag, "_taken"}, 32'(bp_if.predict_taken), 32'(exp_t));
        check({tag, "_ret"}, 32'(bp_if.predict_ret), 32'(exp_r));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bp_if.fetch_pc      = 32'h100;
        bp_if.update_valid  = 1'b0;
        bp_if.update_pc     = '0;
        bp_if.update_target = '0;
        bp_if.update_taken  = 1'b0;
        bp_if.update_kind   = 2'b00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        look("rst", 32'h100, 32'h104, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        look("idle", 32'h100, 32'h104, 1'b0, 1'b0);

        // Conditional branch counter training and saturation
        upd(32'h100, 32'h80, 1'b1, 2'b00);                 // alloc ctr=10
        look("br_alloc", 32'h100, 32'h80, 1'b1, 1'b0);
        upd(32'h100, 32'h0, 1'b0, 2'b00);                  // 01
        look("br_nt1", 32'h100, 32'h104, 1'b0, 1'b0);
        upd(32'h100, 32'h0, 1'b0, 2'b00);                  // 00
        look("br_nt2", 32'h100, 32'h104, 1'b0, 1'b0);
        upd(32'h100, 32'h0, 1'b0, 2'b00);                  // stays 00
        look("br_nt3", 32'h100, 32'h104, 1'b0, 1'b0);
        upd(32'h100, 32'h80, 1'b1, 2'b00);                 // 01
        look("br_t1", 32'h100, 32'h104, 1'b0, 1'b0);
        upd(32'h100, 32'h80, 1'b1, 2'b00);                 // 10
        look("br_t2", 32'h100, 32'h80, 1'b1, 1'b0);
        upd(32'h100, 32'h80, 1'b1, 2'b00);                 // 11
        upd(32'h100, 32'h80, 1'b1, 2'b00);                 // stays 11
        upd(32'h100, 32'h0, 1'b0, 2'b00);                  // 10
        look("br_sat_hi", 32'h100, 32'h80, 1'b1, 1'b0);

        // Aliasing on index 0 and untaken miss leaving the BTB alone
        upd(32'h140, 32'h200, 1'b1, 2'b00);
        look("alias_old", 32'h100, 32'h104, 1'b0, 1'b0);
        look("alias_new", 32'h140, 32'h200, 1'b1, 1'b0);
        upd(32'h180, 32'h999, 1'b0, 2'b00);
        look("miss_nt_keep", 32'h140, 32'h200, 1'b1, 1'b0);
        look("miss_nt_none", 32'h180, 32'h184, 1'b0, 1'b0);

        // Call / return through the RAS
        upd(32'h410, 32'h204, 1'b1, 2'b11);                // ret entry, pop on empty is a no-op
        look("ret_empty", 32'h410, 32'h414, 1'b0, 1'b0);
        upd(32'h200, 32'h400, 1'b1, 2'b10);                // push 0x204
        look("call", 32'h200, 32'h400, 1'b1, 1'b0);
        look("ret_hit", 32'h410, 32'h204, 1'b1, 1'b1);
        upd(32'h410, 32'h204, 1'b1, 2'b11);                // pop
        look("ret_popped", 32'h410, 32'h414, 1'b0, 1'b0);

        // RAS overflow: nine calls into an eight-deep stack
        upd(32'h2034, 32'h0, 1'b1, 2'b11);                 // ret entry at index 13
        for (int i = 0; i < 9; i++) upd(32'h1000 + 32'(4 * i), 32'h5000, 1'b1, 2'b10);
        for (int i = 0; i < 8; i++) begin
            look($sformatf("ovf_pop%0d", i), 32'h2034, 32'h1024 - 32'(4 * i), 1'b1, 1'b1);
            upd(32'h2034, 32'h0, 1'b1, 2'b11);
        end
        look("ovf_empty", 32'h2034, 32'h2038, 1'b0, 1'b0);
        upd(32'h2034, 32'h0, 1'b1, 2'b11);                 // ninth pop, no-op
        look("ovf_ninth", 32'h2034, 32'h2038, 1'b0, 1'b0);
        upd(32'h3000, 32'h6000, 1'b1, 2'b10);              // push 0x3004
        look("no_underflow", 32'h2034, 32'h3004, 1'b1, 1'b1);

        // Same-cycle update and lookup returns pre-update contents
        upd(32'h100, 32'h80, 1'b1, 2'b00);
        look("same_pre", 32'h100, 32'h80, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        bp_if.update_pc     = 32'h100;
        bp_if.update_target = 32'h500;
        bp_if.update_taken  = 1'b1;
        bp_if.update_kind   = 2'b01;
        bp_if.update_valid  = 1'b1;
        look("same_cycle", 32'h100, 32'h80, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        bp_if.update_valid = 1'b0;
        look("same_after", 32'h100, 32'h500, 1'b1, 1'b0);

        // Reset asserted while an update is presented
        @(posedge clk);
        #1;
        bp_if.update_pc     = 32'h600;
        bp_if.update_target = 32'h700;
        bp_if.update_taken  = 1'b1;
        bp_if.update_kind   = 2'b10;
        bp_if.update_valid  = 1'b1;
        #1;
        reset = 1'b1;
        look("rst_async", 32'h100, 32'h104, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bp_if.update_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        look("rst_btb", 32'h100, 32'h104, 1'b0, 1'b0);
        look("rst_ras", 32'h2034, 32'h2038, 1'b0, 1'b0);
        look("rst_discard", 32'h600, 32'h604, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter BTB_ENTRIES, default 16, giving the number of direct-mapped BTB entries (power of two, 4..64).
REQ-002 The block SHALL have parameter RAS_DEPTH, default 8, giving the return-address-stack entry count (power of two, 2..16).
REQ-003 clk  input  1  single clock for the block; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high; clears all predictor state.
REQ-005 fetch_pc  input  32  PC currently being fetched (lookup address).
REQ-006 predict_pc  output  32  predicted next fetch PC.
REQ-007 predict_taken  output  1  lookup predicted a redirect (predict_pc != fetch_pc+4 source).
REQ-008 predict_ret  output  1  prediction was sourced from the RAS.
REQ-009 update_valid  input  1  resolved control-transfer instruction from execute this cycle.
REQ-010 update_pc  input  32  PC of the resolved instruction.
REQ-011 update_target  input  32  resolved target address.
REQ-012 update_taken  input  1  resolved direction (1 = taken).
REQ-013 update_kind  input  2  00 conditional branch, 01 jal (non-link or rd!=ra), 10 call (jal/jalr with rd=ra), 11 return (jalr rs1=ra, rd=x0).

Function
REQ-014 Index SHALL be fetch_pc[IDX+1:2] with IDX=log2(BTB_ENTRIES); tag SHALL be pc[31:IDX+2]; pc[1:0] SHALL be ignored.
REQ-015 Each BTB entry SHALL hold valid, tag, target[31:0], 2-bit counter ctr, kind[1:0].
REQ-016 Lookup SHALL be combinational from fetch_pc and registered state; hit = valid && tag match.
REQ-017 predict_pc SHALL be: hit&&kind=00&&ctr[1] -> target; hit&&kind in {01,10} -> target; hit&&kind=11&&RAS non-empty -> RAS top; otherwise fetch_pc+4 (mod 2^32).
REQ-018 predict_taken SHALL be 1 exactly when one of the first three cases of REQ-017 applies; predict_ret SHALL be 1 exactly in the RAS case.
REQ-019 Lookup in the same cycle as an update to the same index SHALL return the pre-update contents (write at posedge).
REQ-020 On update_valid with hit at update_pc: kind=00 counter SHALL saturate-increment if taken, saturate-decrement if not (00 min, 11 max); target and kind SHALL be rewritten when update_taken.
REQ-021 On update_valid with miss and update_taken: entry SHALL be allocated (overwriting any occupant) with valid=1, new tag, target=update_target, kind=update_kind, ctr=2'b10.
REQ-022 On update_valid with miss and !update_taken: BTB SHALL be unchanged.
REQ-023 RAS SHALL be a circular buffer with top pointer and count (0..RAS_DEPTH), updated only from the update port.
REQ-024 update_valid&&update_kind=10&&update_taken SHALL push update_pc+4; when full, the push SHALL overwrite the oldest entry and count SHALL stay RAS_DEPTH.
REQ-025 update_valid&&update_kind=11&&update_taken SHALL pop; pop when empty SHALL be a no-op (no pointer underflow).
REQ-026 BTB update and RAS push/pop from one update SHALL occur in the same posedge; latency from update to visible lookup effect SHALL be 1 cycle.

Reset
REQ-027 While reset=1, all BTB valid bits and RAS count SHALL be 0 immediately (asynchronous); ctr/target/tag contents SHALL be don't-care.
REQ-028 After reset every lookup SHALL yield predict_pc=fetch_pc+4, predict_taken=0, predict_ret=0; reset asserted mid-stream SHALL discard any update presented that cycle.

Verification
REQ-029 Reset, fetch_pc=0x100 -> predict_pc=0x104, predict_taken=0, predict_ret=0.
REQ-030 Update pc=0x100 kind=00 taken target=0x80, next cycle fetch 0x100 -> predict_pc=0x80 (ctr=10); two not-taken updates -> predict_pc=0x104 (ctr=00); third not-taken keeps ctr=00.
REQ-031 Aliasing: allocate 0x100 (target 0x80), then taken update at 0x140 (same index, different tag; target 0x200) -> fetch 0x100 predicts 0x104, fetch 0x140 predicts 0x200.
REQ-032 Call at 0x200 (kind=10, taken, target 0x400) then ret entry allocated at 0x410 (kind=11, taken) with RAS holding 0x204 -> fetch 0x410 gives predict_pc=0x204, predict_ret=1; after the pop, RAS empty -> 0x414.
REQ-033 Nine calls with RAS_DEPTH=8 from pcs 0x1000..0x1020 step 4 -> eight pops return 0x1024 down to 0x1008; ninth pop no-op, ret lookup falls to pc+4.
REQ-034 Update to 0x100 and lookup of 0x100 in same cycle -> lookup returns old prediction; assert reset mid-update -> all lookups pc+4.
